// File: rtl/guess_game_core_if.sv
// Player-side bus of the number-guessing engine: controls and guess in, grading and game state out.
// The master drives New_Game/Load/Guess_in; the slave (the core) returns everything else.
interface guess_game_core_if #(
   parameter int DIGITS    = 2,
   parameter int MAX_TRIES = 7
);
   localparam int TW = $clog2(MAX_TRIES + 1);

   logic                  New_Game;
   logic                  Load;
   logic [4*DIGITS-1:0]   Guess_in;
   logic [2:0]            Result;
   logic [4*DIGITS-1:0]   Low_bcd;
   logic [4*DIGITS-1:0]   High_bcd;
   logic [TW-1:0]         Tries_left;
   logic [4*DIGITS-1:0]   Secret;
   logic                  Win;
   logic                  Lose;

   modport master (
      output New_Game, Load, Guess_in,
      input  Result, Low_bcd, High_bcd, Tries_left, Secret, Win, Lose
   );

   modport slave (
      input  New_Game, Load, Guess_in,
      output Result, Low_bcd, High_bcd, Tries_left, Secret, Win, Lose
   );
endinterface

// File: rtl/guess_game_core.sv
// Number-guessing engine: LFSR-drawn BCD secret, graded guesses under a try budget, 7-segment scanner.
// Define GUESS_BEEP_TONE_EN to make the beeper a square tone while won; otherwise it follows Win.
module guess_game_core #(
   parameter int          DIGITS    = 2,
   parameter int          MAX_TRIES = 7,
   parameter int          SCAN_DIV  = 25000,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          BEEP_DIV  = 12500
) (
   input  logic                CLK,
   input  logic                Reset,
   guess_game_core_if.slave    gif,
   output logic [2*DIGITS-1:0] COM,
   output logic [6:0]          Seg,
   output logic                beeper
);
   localparam int W   = 4 * DIGITS;
   localparam int TW  = $clog2(MAX_TRIES + 1);
   localparam int NS  = 2 * DIGITS;
   localparam int SW  = $clog2(NS);
   localparam int CW  = $clog2(SCAN_DIV + 1);
   localparam int DCW = $clog2(DIGITS + 1);

   localparam logic [W-1:0]   ALL_NINES  = {DIGITS{4'h9}};
   localparam logic [TW-1:0]  TRIES_INIT = TW'(MAX_TRIES);
   localparam logic [DCW-1:0] LAST_DIGIT = DCW'(DIGITS - 1);
   localparam logic [SW-1:0]  HALF       = SW'(DIGITS);
   localparam logic [SW-1:0]  LAST_SLOT  = SW'(NS - 1);
   localparam logic [CW-1:0]  SCAN_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [6:0]     SEG_DASH   = 7'b1111110;

   if (DIGITS < 1 || DIGITS > 4 || MAX_TRIES < 1 || MAX_TRIES > 15 || SCAN_DIV < 1 ||
       BEEP_DIV < 1 || LFSR_SEED == 16'h0000) begin : g_param_check
      $error("guess_game_core: illegal parameter value");
   end

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_PLAY, S_WIN, S_LOSE} state_t;

   state_t         state, state_nxt;
   logic [15:0]    lfsr;
   logic           load_d;
   logic           load_rise;
   logic           nib_ok;
   logic           guess_bad;
   logic [DCW-1:0] digit_cnt;
   logic [W-1:0]   secret, low, high;
   logic [TW-1:0]  tries;
   logic [2:0]     result;
   logic           win_o, lose_o;
   logic [CW-1:0]  scan_cnt;
   logic [SW-1:0]  slot;
   logic [SW-1:0]  dig_idx;
   logic [W-1:0]   disp_src;
   logic [3:0]     disp_nib;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b0000001;
         4'd1:    seg_of = 7'b1001111;
         4'd2:    seg_of = 7'b0010010;
         4'd3:    seg_of = 7'b0000110;
         4'd4:    seg_of = 7'b1001100;
         4'd5:    seg_of = 7'b0100100;
         4'd6:    seg_of = 7'b0100000;
         4'd7:    seg_of = 7'b0001111;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0000100;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   assign load_rise = gif.Load & ~load_d;
   assign nib_ok    = (lfsr[3:0] <= 4'd9);

   always_comb begin
      guess_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (gif.Guess_in[4*i +: 4] > 4'd9) guess_bad = 1'b1;
      end
   end

   // Polynomial x^16+x^14+x^13+x^11+1 keeps running in every state so the secret depends on timing.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         lfsr   <= LFSR_SEED;
         load_d <= 1'b0;
      end else begin
         lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         load_d <= gif.Load;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // New_Game outranks everything, including a Load edge in the same cycle.
   always_comb begin
      state_nxt = state;
      if (gif.New_Game) begin
         state_nxt = S_ARM;
      end else begin
         case (state)
            S_ARM:
               if (nib_ok && digit_cnt == LAST_DIGIT) state_nxt = S_PLAY;
            S_PLAY:
               if (load_rise && !guess_bad) begin
                  if (gif.Guess_in == secret)   state_nxt = S_WIN;
                  else if (tries == TW'(1))     state_nxt = S_LOSE;
               end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      win_o  = 1'b0;
      lose_o = 1'b0;
      case (state)
         S_WIN:   win_o  = 1'b1;
         S_LOSE:  lose_o = 1'b1;
         default: ;
      endcase
   end

   // Valid packed BCD orders like the number it encodes, so guesses compare as plain unsigned.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         secret    <= '0;
         low       <= '0;
         high      <= ALL_NINES;
         tries     <= TRIES_INIT;
         result    <= 3'd0;
         digit_cnt <= '0;
      end else if (gif.New_Game) begin
         low       <= '0;
         high      <= ALL_NINES;
         tries     <= TRIES_INIT;
         result    <= 3'd0;
         digit_cnt <= '0;
      end else begin
         case (state)
            S_ARM:
               if (nib_ok) begin
                  secret    <= (secret << 4) | W'(lfsr[3:0]);
                  digit_cnt <= digit_cnt + DCW'(1);
               end
            S_PLAY:
               if (load_rise) begin
                  if (guess_bad) begin
                     result <= 3'd4;
                  end else if (gif.Guess_in == secret) begin
                     result <= 3'd3;
                  end else if (gif.Guess_in < secret) begin
                     result <= 3'd1;
                     tries  <= tries - TW'(1);
                     if (gif.Guess_in > low) low <= gif.Guess_in;
                  end else begin
                     result <= 3'd2;
                     tries  <= tries - TW'(1);
                     if (gif.Guess_in < high) high <= gif.Guess_in;
                  end
               end
            default: ;
         endcase
      end
   end

   assign gif.Result     = result;
   assign gif.Low_bcd    = low;
   assign gif.High_bcd   = high;
   assign gif.Tries_left = tries;
   assign gif.Secret     = secret;
   assign gif.Win        = win_o;
   assign gif.Lose       = lose_o;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         scan_cnt <= '0;
         slot     <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         slot     <= (slot == LAST_SLOT) ? '0 : slot + SW'(1);
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

   // Left half of the bank shows the lower bound, right half the upper; a finished game shows the secret twice.
   always_comb begin
      dig_idx = (slot < HALF) ? slot : slot - HALF;
      if (state == S_WIN || state == S_LOSE) disp_src = secret;
      else if (slot < HALF)                  disp_src = low;
      else                                   disp_src = high;
      disp_nib = disp_src[4*(DIGITS-1-int'(dig_idx)) +: 4];
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         COM <= '1;
         Seg <= 7'b1111111;
      end else begin
         COM <= ~(NS'(1) << slot);
         Seg <= (state == S_IDLE || state == S_ARM) ? SEG_DASH : seg_of(disp_nib);
      end
   end

`ifdef GUESS_BEEP_TONE_EN
   localparam int BW = $clog2(BEEP_DIV + 1);

   logic [BW-1:0] beep_cnt;
   logic          tone;

   // Tone restarts high on the first WIN edge and flips once per BEEP_DIV cycles.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         beep_cnt <= '0;
         tone     <= 1'b0;
      end else if (state != S_WIN) begin
         beep_cnt <= '0;
         tone     <= 1'b0;
      end else begin
         if (beep_cnt == '0) tone <= ~tone;
         beep_cnt <= (beep_cnt == BW'(BEEP_DIV - 1)) ? '0 : beep_cnt + BW'(1);
      end
   end

   assign beeper = tone;
`else
   assign beeper = win_o;
`endif
endmodule

// File: tb/tb_guess_game_core.sv
// Scoreboard bench for guess_game_core: a game-rule model predicts each transaction, a monitor grades it.
module tb_guess_game_core;
   localparam int          DIGITS    = 2;
   localparam int          MAX_TRIES = 3;
   localparam int          SCAN_DIV  = 4;
   localparam logic [15:0] SEED      = 16'hACE1;

   localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_WIN = 3, M_LOSE = 4;

   typedef struct {
      int    result;
      int    low;
      int    high;
      int    tries;
      int    win;
      int    lose;
      string tag;
   } exp_t;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [3:0]  COM;
   logic [6:0]  Seg;
   logic        beeper;

   int          total = 0;
   int          bad   = 0;
   exp_t        sb[$];
   logic [15:0] m_lfsr;
   int          m_state, m_low, m_high, m_tries, m_result, m_secret;
   logic        prev_load;

   guess_game_core_if #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)) gif ();

   guess_game_core #(
      .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .SCAN_DIV(SCAN_DIV), .LFSR_SEED(SEED), .BEEP_DIV(8)
   ) dut (
      .CLK(CLK), .Reset(Reset), .gif(gif), .COM(COM), .Seg(Seg), .beeper(beeper)
   );

   always #5 CLK = ~CLK;

   // Shift-register polynomial x^16+x^14+x^13+x^11+1, new bit entering at the bottom.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge CLK or posedge Reset) begin
      if (Reset) m_lfsr <= SEED;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int seg_ref(input int d);
      case (d)
         0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
         3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
         6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit ng, input bit ld, input logic [7:0] g);
      gif.New_Game = ng;
      gif.Load     = ld;
      gif.Guess_in = g;
   endtask

   task automatic pushExp(input string tag);
      exp_t e;
      e.result = m_result;
      e.low    = m_low;
      e.high   = m_high;
      e.tries  = m_tries;
      e.win    = (m_state == M_WIN)  ? 1 : 0;
      e.lose   = (m_state == M_LOSE) ? 1 : 0;
      e.tag    = tag;
      sb.push_back(e);
   endtask

   task automatic modelGuess(input logic [7:0] g);
      int v;
      v = bcd2int(g);
      if (m_state == M_PLAY) begin
         if (g[7:4] > 4'd9 || g[3:0] > 4'd9) begin
            m_result = 4;
         end else if (v == m_secret) begin
            m_result = 3;
            m_state  = M_WIN;
         end else begin
            m_result = (v < m_secret) ? 1 : 2;
            if (v < m_secret) m_low  = (v > m_low)  ? v : m_low;
            else              m_high = (v < m_high) ? v : m_high;
            m_tries--;
            if (m_tries == 0) m_state = M_LOSE;
         end
      end
      pushExp("guess");
   endtask

   task automatic doGuess(input logic [7:0] g);
      applyStimulus(1'b0, 1'b1, g);
      modelGuess(g);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, g);
      @(negedge CLK);
   endtask

   task automatic holdLoad(input logic [7:0] g, input int n);
      applyStimulus(1'b0, 1'b1, g);
      modelGuess(g);
      repeat (n) @(negedge CLK);
      applyStimulus(1'b0, 1'b0, g);
      @(negedge CLK);
      checkOutput("held_load_tries", int'(gif.Tries_left), m_tries);
   endtask

   // Expected secret: walk the LFSR stream, keeping decimal low nibbles until DIGITS are collected.
   task automatic startGame(input bit with_load, input logic [7:0] g);
      logic [15:0] v;
      int cnt, cycles, sec;
      @(negedge CLK);
      applyStimulus(1'b1, with_load, g);
      m_state = M_ARM; m_low = 0; m_high = 99; m_tries = MAX_TRIES; m_result = 0;
      pushExp(with_load ? "new_game_with_load" : "new_game");
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, g);
      v = m_lfsr; cnt = 0; cycles = 0; sec = 0;
      while (cnt < DIGITS && cycles < 1000) begin
         cycles++;
         if (v[3:0] <= 4'd9) begin
            sec = sec * 10 + int'(v[3:0]);
            cnt++;
         end
         v = lfsr_next(v);
      end
      repeat (cycles) @(negedge CLK);
      m_secret = sec;
      m_state  = M_PLAY;
      checkOutput("secret", bcd2int(gif.Secret), sec);
   endtask

   task automatic scanCheck(input int n);
      int slot, zeros, val, d, expv;
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         slot = -1; zeros = 0;
         for (int i = 0; i < 4; i++) if (COM[i] == 1'b0) begin slot = i; zeros++; end
         if (zeros != 1) begin
            total++; bad++;
            $display("[TB] FAIL com_onehot: got %b, required exactly one low bit", COM);
         end else begin
            if (m_state == M_IDLE || m_state == M_ARM) begin
               expv = 7'b1111110;
            end else begin
               if (m_state == M_WIN || m_state == M_LOSE) val = m_secret;
               else                                      val = (slot < 2) ? m_low : m_high;
               d    = (slot % 2 == 0) ? val / 10 : val % 10;
               expv = seg_ref(d);
            end
            checkOutput($sformatf("seg_slot%0d", slot), int'(Seg), expv);
         end
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_result"}, int'(gif.Result), 0);
      checkOutput({tag, "_low"},    int'(gif.Low_bcd), 8'h00);
      checkOutput({tag, "_high"},   int'(gif.High_bcd), 8'h99);
      checkOutput({tag, "_tries"},  int'(gif.Tries_left), MAX_TRIES);
      checkOutput({tag, "_secret"}, int'(gif.Secret), 0);
      checkOutput({tag, "_win"},    int'(gif.Win), 0);
      checkOutput({tag, "_lose"},   int'(gif.Lose), 0);
      checkOutput({tag, "_com"},    int'(COM), 4'hF);
      checkOutput({tag, "_seg"},    int'(Seg), 7'h7F);
      checkOutput({tag, "_beeper"}, int'(beeper), 0);
   endtask

   function automatic int pickWrong();
      int v;
      for (int i = 0; i < 100; i++) begin
         v = int'($urandom_range(99, 0));
         if (v != m_secret) return v;
      end
      return (m_secret + 1) % 100;
   endfunction

   // Monitor: every Load rising edge or New_Game seen on the bus is one transaction to grade.
   initial begin
      bit   trig;
      exp_t e;
      prev_load = 1'b0;
      forever begin
         @(posedge CLK);
         trig      = !Reset && (gif.New_Game || (gif.Load && !prev_load));
         prev_load = Reset ? 1'b0 : gif.Load;
         @(negedge CLK);
         if (trig) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL unexpected_txn: got a transaction, required none queued");
            end else begin
               e = sb.pop_front();
               checkOutput({e.tag, "_result"}, int'(gif.Result), e.result);
               checkOutput({e.tag, "_low"},    bcd2int(gif.Low_bcd), e.low);
               checkOutput({e.tag, "_high"},   bcd2int(gif.High_bcd), e.high);
               checkOutput({e.tag, "_tries"},  int'(gif.Tries_left), e.tries);
               checkOutput({e.tag, "_win"},    int'(gif.Win), e.win);
               checkOutput({e.tag, "_lose"},   int'(gif.Lose), e.lose);
            end
         end
      end
   end

   initial begin
      logic [7:0] g;
      logic [3:0] exp_com;
      int         guard, w;

      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00);
      m_state = M_IDLE; m_low = 0; m_high = 99; m_tries = MAX_TRIES; m_result = 0; m_secret = 0;
      #12;
      checkResetValues("por");
      @(negedge CLK);
      Reset = 1'b0;

      for (int k = 1; k <= 24; k++) begin
         @(negedge CLK);
         exp_com = ~(4'b0001 << (((k - 1) / SCAN_DIV) % 4));
         checkOutput("com_scan", int'(COM), int'(exp_com));
         checkOutput("seg_idle_dash", int'(Seg), 7'b1111110);
      end

      $display("[TB] load edge while idle");
      doGuess(8'h55);

      $display("[TB] game 1: low, high, hit");
      startGame(1'b0, 8'h00);
      doGuess(to_bcd((m_secret > 0) ? int'($urandom_range(m_secret - 1, 0)) : 99));
      scanCheck(8);
      doGuess(to_bcd((m_secret < 99) ? int'($urandom_range(99, m_secret + 1)) : 0));
      doGuess(to_bcd(m_secret));
      checkOutput("beeper_win", int'(beeper), 1);
      scanCheck(8);

      $display("[TB] game 2: bad guess, held load, lose");
      startGame(1'b0, 8'h00);
      doGuess(8'h4A);
      holdLoad(to_bcd(pickWrong()), 10);
      doGuess(to_bcd(pickWrong()));
      doGuess(to_bcd(pickWrong()));
      doGuess(to_bcd(m_secret));
      checkOutput("beeper_lose", int'(beeper), 0);
      scanCheck(8);

      $display("[TB] game 3: new game beats load edge");
      startGame(1'b0, 8'h00);
      doGuess(to_bcd(pickWrong()));
      startGame(1'b1, to_bcd(m_secret));
      doGuess(to_bcd(m_secret));

      $display("[TB] random games");
      for (int gn = 0; gn < 5; gn++) begin
         startGame(1'b0, 8'h00);
         guard = 0;
         while (m_state == M_PLAY && guard < 20) begin
            guard++;
            if ($urandom_range(7, 0) == 0)      g = {4'($urandom_range(9, 0)), 4'(10 + $urandom_range(5, 0))};
            else if ($urandom_range(3, 0) == 0) g = to_bcd(m_secret);
            else                                g = to_bcd(int'($urandom_range(99, 0)));
            doGuess(g);
         end
      end

      $display("[TB] reset mid-play");
      startGame(1'b0, 8'h00);
      doGuess(to_bcd(pickWrong()));
      #2 Reset = 1'b1;
      #1 checkResetValues("reset_midplay");
      m_state = M_IDLE; m_low = 0; m_high = 99; m_tries = MAX_TRIES; m_result = 0; m_secret = 0;
      @(negedge CLK);
      Reset = 1'b0;
      startGame(1'b0, 8'h00);
      doGuess(to_bcd(m_secret));

      w = 0;
      while (sb.size() != 0 && w < 50) begin
         @(negedge CLK);
         w++;
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("[TB] FAIL drain: got %0d pending transactions, required 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
